scene_sequencer: RTL and testbench

- Per-frame controller for the pixel colour datapath.
- Owns the scroll offset and move pulse that feed the block repeater, Pikachu's vertical position and the sprite animation select.
- Sequences all state once per video frame, at the start of vertical blanking, from the raster x/y counters.
- Sits between the VGA timing generator and the colour mux. Replaces the free-running offset/move sources.

---
 rtl/scene_pkg.sv | 20 ++
 rtl/frame_tick_gen.sv | 40 ++++
 rtl/scene_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_scene_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scene_pkg.sv
// scene_pkg: types and screen/ground constants shared by the scene sequencer
// and its frame tick generator.
//   jump_state_t : jump FSM encoding (IDLE, RISE, HOLD, FALL)
//   H_ACTIVE     : visible pixels per line
//   V_ACTIVE     : visible lines; the frame tick fires at y == V_ACTIVE, x == 0
//   GROUND_Y     : Pikachu top-edge row when standing
package scene_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        HOLD = 2'd2,
        FALL = 2'd3
    } jump_state_t;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int GROUND_Y = 336;

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: one-clock pulse at the start of vertical blanking.
// The raster position (y == V_LINE, x == 0) may be presented for several
// clocks; only its first clock produces a tick.
// Ports:
//   clk  in   clock
//   rst  in   synchronous reset, active-high
//   x    in   [9:0] raster column
//   y    in   [9:0] raster row
//   tick out  frame tick (combinational, qualified by registered history)
module frame_tick_gen
    import scene_pkg::*;
#(
    parameter int V_LINE = V_ACTIVE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       tick
);

    logic at_start;
    logic seen_d;
    logic seen_q;

    always_comb begin
        at_start = (y == 10'(V_LINE)) && (x == 10'd0);
        seen_d   = at_start;
        tick     = at_start && !seen_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q <= 1'b0;
        end else begin
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/scene_sequencer.sv
// scene_sequencer: per-frame controller for the pixel colour datapath.
// Once per frame (at the start of vertical blanking) it advances the scroll
// offset, the jump FSM that positions Pikachu and the sprite animation.
// Optional build macro JUMP_BUFFER_EN: a button press during FALL is kept
// and re-launches the jump on the tick after landing.
// Ports:
//   clk      in   clock
//   rst      in   synchronous reset, active-high
//   x, y     in   [9:0] raster column / row
//   run      in   game running; 0 freezes all motion
//   jump_btn in   jump button level, already synchronous to clk
//   offset   out  [9:0] scroll offset to the block repeater
//   move     out  one-clock pulse when offset changes
//   pika_y   out  [9:0] Pikachu top-edge row
//   anim     out  sprite frame select
//   jumping  out  jump FSM is not IDLE
//
// state | meaning
// IDLE  | standing on ground, animating, waiting for a pending press
// RISE  | moving up JUMP_STEP per frame until the apex
// HOLD  | parked at the apex for HOLD_FRAMES frames
// FALL  | moving down JUMP_STEP per frame until back on ground
module scene_sequencer
    import scene_pkg::*;
#(
    parameter int WRAP        = 640,
    parameter int SCROLL_STEP = 2,
    parameter int SCROLL_DIV  = 1,
    parameter int JUMP_HEIGHT = 64,
    parameter int JUMP_STEP   = 4,
    parameter int HOLD_FRAMES = 8,
    parameter int ANIM_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       run,
    input  logic       jump_btn,
    output logic [9:0] offset,
    output logic       move,
    output logic [9:0] pika_y,
    output logic       anim,
    output logic       jumping
);

`ifdef JUMP_BUFFER_EN
    localparam logic BUFFER_IN_FALL = 1'b1;
`else
    localparam logic BUFFER_IN_FALL = 1'b0;
`endif

    localparam logic [10:0] APEX_Y = 11'(GROUND_Y - JUMP_HEIGHT);

    logic        tick;
    logic        btn_rise;
    logic [10:0] offset_sum;
    logic [10:0] rise_y;
    logic [10:0] fall_y;

    jump_state_t state_d,    state_q;
    logic [9:0]  offset_d,   offset_q;
    logic        move_d,     move_q;
    logic [9:0]  pika_y_d,   pika_y_q;
    logic        anim_d,     anim_q;
    logic [7:0]  div_cnt_d,  div_cnt_q;
    logic [7:0]  hold_cnt_d, hold_cnt_q;
    logic [7:0]  anim_cnt_d, anim_cnt_q;
    logic        pending_d,  pending_q;
    logic        btn_d,      btn_q;

    frame_tick_gen #(.V_LINE(V_ACTIVE)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .x    (x),
        .y    (y),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        move_d     = 1'b0;
        pika_y_d   = pika_y_q;
        anim_d     = anim_q;
        div_cnt_d  = div_cnt_q;
        hold_cnt_d = hold_cnt_q;
        anim_cnt_d = anim_cnt_q;
        pending_d  = pending_q;
        btn_d      = jump_btn;
        btn_rise   = jump_btn && !btn_q;
        offset_sum = {1'b0, offset_q} + 11'(SCROLL_STEP);
        rise_y     = {1'b0, pika_y_q} - 11'(JUMP_STEP);
        fall_y     = {1'b0, pika_y_q} + 11'(JUMP_STEP);

        if (tick && run) begin
            if (div_cnt_q == 8'(SCROLL_DIV - 1)) begin
                div_cnt_d = 8'd0;
                move_d    = 1'b1;
                offset_d  = (offset_sum >= 11'(WRAP)) ? 10'(offset_sum - 11'(WRAP))
                                                      : offset_sum[9:0];
            end else begin
                div_cnt_d = div_cnt_q + 8'd1;
            end

            if (state_q == IDLE) begin
                if (anim_cnt_q == 8'(ANIM_FRAMES - 1)) begin
                    anim_cnt_d = 8'd0;
                    anim_d     = !anim_q;
                end else begin
                    anim_cnt_d = anim_cnt_q + 8'd1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        state_d   = RISE;
                        pending_d = 1'b0;
                    end
                end
                RISE: begin
                    if (rise_y <= APEX_Y) begin
                        pika_y_d   = APEX_Y[9:0];
                        state_d    = HOLD;
                        hold_cnt_d = 8'd0;
                    end else begin
                        pika_y_d = rise_y[9:0];
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == 8'(HOLD_FRAMES - 1)) begin
                        state_d = FALL;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
                FALL: begin
                    if (fall_y >= 11'(GROUND_Y)) begin
                        pika_y_d = 10'(GROUND_Y);
                        state_d  = IDLE;
                    end else begin
                        pika_y_d = fall_y[9:0];
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Evaluated after the tick so an edge coinciding with a tick is kept
        // for the following tick rather than serviced now.
        if (btn_rise && run) begin
            pending_d = (state_q == IDLE) || (BUFFER_IN_FALL && (state_q == FALL));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            offset_q   <= 10'd0;
            move_q     <= 1'b0;
            pika_y_q   <= 10'(GROUND_Y);
            anim_q     <= 1'b0;
            div_cnt_q  <= 8'd0;
            hold_cnt_q <= 8'd0;
            anim_cnt_q <= 8'd0;
            pending_q  <= 1'b0;
            btn_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            move_q     <= move_d;
            pika_y_q   <= pika_y_d;
            anim_q     <= anim_d;
            div_cnt_q  <= div_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            anim_cnt_q <= anim_cnt_d;
            pending_q  <= pending_d;
            btn_q      <= btn_d;
        end
    end

    always_comb begin
        offset  = offset_q;
        move    = move_q;
        pika_y  = pika_y_q;
        anim    = anim_q;
        jumping = (state_q != IDLE);
    end

endmodule

// File: tb/tb_scene_sequencer.sv
module tb_scene_sequencer;

    localparam int WRAP   = 640;
    localparam int STEP   = 2;
    localparam int DIV    = 1;
    localparam int GROUND = 336;
    localparam int HEIGHT = 64;
    localparam int JSTEP  = 4;
    localparam int HOLD   = 8;
    localparam int ANIM   = 8;
`ifdef JUMP_BUFFER_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x = 10'd0;
    logic [9:0] y = 10'd0;
    logic       run = 1'b0;
    logic       jump_btn = 1'b0;
    logic [9:0] offset;
    logic       move;
    logic [9:0] pika_y;
    logic       anim;
    logic       jumping;

    scene_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .y        (y),
        .run      (run),
        .jump_btn (jump_btn),
        .offset   (offset),
        .move     (move),
        .pika_y   (pika_y),
        .anim     (anim),
        .jumping  (jumping)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int cyc;
        int off;
        bit mv;
        int py;
        bit an;
        bit jp;
    } exp_t;

    exp_t sb_q[$];
    bit   mon_en = 1'b0;

    // Reference model: state 0=idle 1=rise 2=hold 3=fall.
    int m_off, m_y, m_div, m_hold, m_acnt, m_st;
    bit m_anim, m_pend, m_mv;

    task automatic model_reset();
        m_off = 0; m_y = GROUND; m_div = 0; m_hold = 0; m_acnt = 0; m_st = 0;
        m_anim = 0; m_pend = 0; m_mv = 0;
    endtask

    task automatic model_press();
        if (run) m_pend = (m_st == 0) || (BUF && m_st == 3);
    endtask

    task automatic model_tick();
        exp_t e;
        m_mv = 0;
        if (run) begin
            m_div++;
            if (m_div == DIV) begin
                m_div = 0;
                m_mv  = 1;
                m_off = (m_off + STEP) % WRAP;
            end
            if (m_st == 0) begin
                m_acnt++;
                if (m_acnt == ANIM) begin
                    m_acnt = 0;
                    m_anim = !m_anim;
                end
            end
            case (m_st)
                0: if (m_pend) begin m_st = 1; m_pend = 0; end
                1: begin
                    m_y = m_y - JSTEP;
                    if (GROUND - m_y >= HEIGHT) begin m_y = GROUND - HEIGHT; m_st = 2; m_hold = 0; end
                end
                2: begin
                    m_hold++;
                    if (m_hold == HOLD) m_st = 3;
                end
                default: begin
                    m_y = m_y + JSTEP;
                    if (m_y >= GROUND) begin m_y = GROUND; m_st = 0; end
                end
            endcase
        end
        e.cyc = cyc + 1; e.off = m_off; e.mv = m_mv; e.py = m_y; e.an = m_anim; e.jp = (m_st != 0);
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                chk("sb_cycle", cyc, e.cyc);
                chk("sb_offset", offset, e.off);
                chk("sb_move", move, e.mv);
                chk("sb_pika_y", pika_y, e.py);
                chk("sb_anim", anim, e.an);
                chk("sb_jumping", jumping, e.jp);
            end else begin
                chk("move_idle", move, 0);
            end
        end
    end

    task automatic tick_frame(input int hold = 1);
        @(posedge clk); #1;
        model_tick();
        x = 10'd0; y = 10'd480;
        repeat (hold) @(posedge clk);
        #1;
        y = 10'd0; x = 10'd5;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_frame(1);
    endtask

    task automatic press();
        @(posedge clk); #1;
        jump_btn = 1'b1;
        model_press();
        @(posedge clk); #1;
        jump_btn = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("rst_offset", offset, 0);
        chk("rst_move", move, 0);
        chk("rst_pika_y", pika_y, GROUND);
        chk("rst_anim", anim, 0);
        chk("rst_jumping", jumping, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("init_offset", offset, 0);
        chk("init_move", move, 0);
        chk("init_pika_y", pika_y, GROUND);
        chk("init_anim", anim, 0);
        chk("init_jumping", jumping, 0);
        mon_en = 1'b1;

        // Five scroll frames
        run = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick_frame(1);
            chk("scroll_offset", offset, 2 * i);
        end

        // Frame position held for four clocks: one tick only
        tick_frame(4);
        chk("held_offset", offset, 12);
        repeat (3) @(posedge clk);
        #1;
        chk("held_no_extra", offset, 12);

        // Full jump profile
        press();
        tick_frame(1);
        chk("jump_start", jumping, 1);
        for (int i = 1; i <= 16; i++) begin
            tick_frame(1);
            chk("rise_y", pika_y, GROUND - JSTEP * i);
        end
        for (int i = 0; i < 8; i++) begin
            tick_frame(1);
            chk("hold_y", pika_y, GROUND - HEIGHT);
        end
        for (int i = 1; i <= 16; i++) begin
            tick_frame(1);
            chk("fall_y", pika_y, GROUND - HEIGHT + JSTEP * i);
            chk("fall_jumping", jumping, (i < 16));
        end

        // Press during HOLD is discarded
        press();
        ticks(1 + 16 + 3);
        press();
        ticks(5 + 16 + 3);
        chk("hold_press_dropped", jumping, 0);

        // Press during FALL: buffered only with JUMP_BUFFER_EN
        press();
        ticks(1 + 16 + 8 + 5);
        press();
        ticks(11);
        chk("fall_landed", jumping, 0);
        tick_frame(1);
        chk("fall_press_rejump", jumping, BUF);
        ticks(45);
        chk("settle_jumping", jumping, 0);
        chk("settle_y", pika_y, GROUND);

        // Freeze mid-rise at 300
        press();
        ticks(1 + 9);
        chk("freeze_at", pika_y, 300);
        run = 1'b0;
        ticks(10);
        press();
        chk("frozen_y", pika_y, 300);
        run = 1'b1;
        tick_frame(1);
        chk("resume_y", pika_y, 296);
        ticks(60);
        chk("resume_done", jumping, 0);

        // Press while stopped is discarded
        run = 1'b0;
        press();
        run = 1'b1;
        ticks(3);
        chk("stopped_press", jumping, 0);

        // Long scroll run crossing the wrap point
        ticks(330);

        // Reset in the middle of a jump after scroll events
        press();
        ticks(4);
        do_reset();
        tick_frame(1);
        chk("post_reset_offset", offset, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
